// File: rtl/issue_pkg.sv
// Shared issue-path types: instruction word, buffer pointer, field offsets.
// Used by fetch_buffer, fb_storage and the decoder.
package issue_pkg;
  localparam int INSTR_W  = 16;
  localparam int FB_DEPTH = 8;
  localparam int FIELD_W  = 4;
  localparam int OP_LSB   = 12;
  localparam int DES_LSB  = 8;
  localparam int S1_LSB   = 4;
  localparam int S2_LSB   = 0;
  localparam int IME_LSB  = 0;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [$clog2(FB_DEPTH)-1:0] fb_ptr_t;

  function automatic logic [FIELD_W-1:0] op_of(input instr_t i);
    return i[OP_LSB +: FIELD_W];
  endfunction
endpackage

// File: rtl/fb_storage.sv
// Fetch buffer storage: DEPTH x INSTR_W array, two write ports at wptr and
// wptr+1, two read ports at rptr and rptr+1 (modulo DEPTH). Not reset.
module fb_storage
  import issue_pkg::*;
#(
  parameter int DEPTH   = FB_DEPTH,
  parameter int INSTR_W = issue_pkg::INSTR_W
) (
  input  logic                     clk,
  input  logic                     we1,
  input  logic                     we2,
  input  logic [$clog2(DEPTH)-1:0] wptr,
  input  logic [INSTR_W-1:0]       wd1,
  input  logic [INSTR_W-1:0]       wd2,
  input  logic [$clog2(DEPTH)-1:0] rptr,
  output logic [INSTR_W-1:0]       rd1,
  output logic [INSTR_W-1:0]       rd2
);
  localparam int PW = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wptr2;
  logic [PW-1:0]      rptr2;

  assign wptr2 = wptr + PW'(1);
  assign rptr2 = rptr + PW'(1);

  always_ff @(posedge clk) begin
    if (we1) mem[wptr]  <= wd1;
    if (we2) mem[wptr2] <= wd2;
  end

  assign rd1 = mem[rptr];
  assign rd2 = mem[rptr2];
endmodule

// File: rtl/fetch_buffer.sv
// Two-in/two-out circular instruction buffer between fetch and issue.
// Ports: clk, rst (async low), fetch_{1,2}_{vld,instr}, fetch_ready,
// iq_stall, flush_en, new_instr{1,2}_in, ins_new_{1,2}_vld, fb_count,
// fb_empty, fb_full. Macro FETCH_BUF_BYPASS_EN: same-cycle path when empty.
module fetch_buffer
  import issue_pkg::*;
#(
  parameter int DEPTH   = FB_DEPTH,
  parameter int INSTR_W = issue_pkg::INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_1_vld,
  input  logic [INSTR_W-1:0]       fetch_1_instr,
  input  logic                     fetch_2_vld,
  input  logic [INSTR_W-1:0]       fetch_2_instr,
  output logic                     fetch_ready,
  input  logic                     iq_stall,
  input  logic                     flush_en,
  output logic [INSTR_W-1:0]       new_instr1_in,
  output logic [INSTR_W-1:0]       new_instr2_in,
  output logic                     ins_new_1_vld,
  output logic                     ins_new_2_vld,
  output logic [$clog2(DEPTH):0]   fb_count,
  output logic                     fb_empty,
  output logic                     fb_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]      head, tail;
  logic [CW-1:0]      count;
  logic [INSTR_W-1:0] rd1, rd2;
  logic               buf_v1, buf_v2;
  logic               byp;
  logic               push_ok;
  logic [1:0]         push_n, pop_n;

  assign buf_v1      = (count != '0);
  assign buf_v2      = (count > CW'(1));
  assign fetch_ready = (count <= CW'(DEPTH-2));

`ifdef FETCH_BUF_BYPASS_EN
  assign byp = (count == '0) & ~flush_en;
`else
  assign byp = 1'b0;
`endif

  // Bypassed slots taken by issue this cycle never enter storage.
  assign push_ok = fetch_ready & ~flush_en & fetch_1_vld & ~(byp & ~iq_stall);
  assign push_n  = push_ok ? (fetch_2_vld ? 2'd2 : 2'd1) : 2'd0;

  always_comb begin
    ins_new_1_vld = 1'b0;
    ins_new_2_vld = 1'b0;
    new_instr1_in = '0;
    new_instr2_in = '0;
    if (byp) begin
      ins_new_1_vld = fetch_1_vld;
      ins_new_2_vld = fetch_1_vld & fetch_2_vld;
      if (fetch_1_vld)   new_instr1_in = fetch_1_instr;
      if (ins_new_2_vld) new_instr2_in = fetch_2_instr;
    end else begin
      ins_new_1_vld = buf_v1 & ~flush_en;
      ins_new_2_vld = buf_v2 & ~flush_en;
      if (buf_v1) new_instr1_in = rd1;
      if (buf_v2) new_instr2_in = rd2;
    end
  end

  // Storage pops only; a bypass hit has nothing buffered to remove.
  assign pop_n = (iq_stall | byp) ? 2'd0
               : {1'b0, ins_new_1_vld} + {1'b0, ins_new_2_vld};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_en) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  fb_storage #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_storage (
    .clk  (clk),
    .we1  (push_n != 2'd0),
    .we2  (push_n == 2'd2),
    .wptr (tail),
    .wd1  (fetch_1_instr),
    .wd2  (fetch_2_instr),
    .rptr (head),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  assign fb_count = count;
  assign fb_empty = (count == '0);
  assign fb_full  = (count == CW'(DEPTH));

  a_slot2_alone: assert property (
    @(posedge clk) disable iff (!rst) !(fetch_2_vld && !fetch_1_vld));
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: vector table plus queue scoreboard,
// with wrap, mid-stream reset and empty-buffer latency sequences.
module tb_fetch_buffer;
  localparam int DEPTH = 8;
  localparam int IW    = 16;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_1_vld, fetch_2_vld;
  logic [IW-1:0] fetch_1_instr, fetch_2_instr;
  logic          fetch_ready;
  logic          iq_stall, flush_en;
  logic [IW-1:0] new_instr1_in, new_instr2_in;
  logic          ins_new_1_vld, ins_new_2_vld;
  logic [3:0]    fb_count;
  logic          fb_empty, fb_full;

  fetch_buffer #(.DEPTH(DEPTH), .INSTR_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_1_vld   (fetch_1_vld),
    .fetch_1_instr (fetch_1_instr),
    .fetch_2_vld   (fetch_2_vld),
    .fetch_2_instr (fetch_2_instr),
    .fetch_ready   (fetch_ready),
    .iq_stall      (iq_stall),
    .flush_en      (flush_en),
    .new_instr1_in (new_instr1_in),
    .new_instr2_in (new_instr2_in),
    .ins_new_1_vld (ins_new_1_vld),
    .ins_new_2_vld (ins_new_2_vld),
    .fb_count      (fb_count),
    .fb_empty      (fb_empty),
    .fb_full       (fb_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          f1v;
    logic [15:0] f1i;
    bit          f2v;
    logic [15:0] f2i;
    bit          st;
    bit          fl;
    int          cnt;
  } vec_t;

  vec_t          vecs[18];
  logic [IW-1:0] q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit f1v, input logic [15:0] f1i,
                      input bit f2v, input logic [15:0] f2i,
                      input bit st, input bit fl);
    bit byp, rdy, ev1, ev2;
    int npop;
    @(negedge clk);
    fetch_1_vld   = f1v;
    fetch_1_instr = f1i;
    fetch_2_vld   = f2v;
    fetch_2_instr = f2i;
    iq_stall      = st;
    flush_en      = fl;
    #2;
    byp = BYP && (q.size() == 0) && !fl;
    rdy = (q.size() <= DEPTH-2);
    ev1 = !fl && (byp ? f1v : (q.size() >= 1));
    ev2 = !fl && (byp ? (f1v && f2v) : (q.size() >= 2));
    chk("fetch_ready", 32'(fetch_ready), 32'(rdy));
    chk("vld1", 32'(ins_new_1_vld), 32'(ev1));
    chk("vld2", 32'(ins_new_2_vld), 32'(ev2));
    if (ev1) chk("instr1", 32'(new_instr1_in), 32'(byp ? f1i : q[0]));
    if (ev2) chk("instr2", 32'(new_instr2_in), 32'(byp ? f2i : q[1]));
    if (fl) begin
      q.delete();
    end else begin
      npop = (st || byp) ? 0 : int'(ev1) + int'(ev2);
      repeat (npop) void'(q.pop_front());
      if (rdy && f1v && !(byp && !st)) begin
        q.push_back(f1i);
        if (f2v) q.push_back(f2i);
      end
    end
    @(posedge clk);
    #1;
    chk("count", 32'(fb_count), 32'(q.size()));
    chk("empty", 32'(fb_empty), 32'(q.size() == 0));
    chk("full", 32'(fb_full), 32'(q.size() == DEPTH));
  endtask

  initial begin
    vecs[0]  = '{1, 16'hA001, 1, 16'hA002, 1, 0, 2};
    vecs[1]  = '{0, 16'h0000, 0, 16'h0000, 1, 0, 2};
    vecs[2]  = '{0, 16'h0000, 0, 16'h0000, 1, 0, 2};
    vecs[3]  = '{0, 16'h0000, 0, 16'h0000, 1, 0, 2};
    vecs[4]  = '{1, 16'hA003, 1, 16'hA004, 1, 0, 4};
    vecs[5]  = '{1, 16'hA005, 1, 16'hA006, 1, 0, 6};
    vecs[6]  = '{1, 16'hA007, 0, 16'h0000, 1, 0, 7};
    vecs[7]  = '{1, 16'hA008, 1, 16'hA009, 1, 0, 7};
    vecs[8]  = '{0, 16'h0000, 0, 16'h0000, 0, 0, 5};
    vecs[9]  = '{1, 16'hA00A, 1, 16'hA00B, 1, 0, 7};
    vecs[10] = '{1, 16'hA0F0, 1, 16'hA0F1, 0, 0, 5};
    vecs[11] = '{1, 16'hA00C, 0, 16'h0000, 1, 0, 6};
    vecs[12] = '{1, 16'hA00D, 1, 16'hA00E, 1, 0, 8};
    vecs[13] = '{1, 16'hA00F, 0, 16'h0000, 1, 0, 8};
    vecs[14] = '{1, 16'hA0F2, 1, 16'hA0F3, 0, 0, 6};
    vecs[15] = '{1, 16'hB001, 1, 16'hB002, 0, 0, 6};
    vecs[16] = '{1, 16'hC001, 1, 16'hC002, 0, 1, 0};
    vecs[17] = '{0, 16'h0000, 0, 16'h0000, 0, 0, 0};

    rst = 1'b0;
    fetch_1_vld = 0; fetch_2_vld = 0;
    fetch_1_instr = '0; fetch_2_instr = '0;
    iq_stall = 0; flush_en = 0;
    #3;
    chk("rst_count", 32'(fb_count), 0);
    chk("rst_vld1", 32'(ins_new_1_vld), 0);
    chk("rst_vld2", 32'(ins_new_2_vld), 0);
    chk("rst_ready", 32'(fetch_ready), 1);
    chk("rst_empty", 32'(fb_empty), 1);
    chk("rst_full", 32'(fb_full), 0);
    chk("rst_instr1", 32'(new_instr1_in), 0);
    chk("rst_instr2", 32'(new_instr2_in), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].f1v, vecs[i].f1i, vecs[i].f2v, vecs[i].f2i,
           vecs[i].st, vecs[i].fl);
      chk($sformatf("tbl_count[%0d]", i), 32'(fb_count), 32'(vecs[i].cnt));
    end

    // Move head to an odd slot, then stream 2-in/2-out across the wrap.
    step(1, 16'hD000, 0, 16'h0000, 1, 0);
    step(1, 16'hD001, 1, 16'hD002, 0, 0);
    for (int i = 0; i < 23; i++) begin
      step(1, 16'hE000 + 16'(2*i), 1, 16'hE001 + 16'(2*i), 0, 0);
      if (i >= 3) chk("steady_count", 32'(fb_count), 2);
    end

    // Asynchronous reset with four entries held.
    step(0, 16'h0000, 0, 16'h0000, 0, 1);
    step(1, 16'hF001, 1, 16'hF002, 1, 0);
    step(1, 16'hF003, 1, 16'hF004, 1, 0);
    chk("pre_rst_count", 32'(fb_count), 4);
    fetch_1_vld = 0; fetch_2_vld = 0;
    #1;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(fb_count), 0);
    chk("arst_vld1", 32'(ins_new_1_vld), 0);
    chk("arst_vld2", 32'(ins_new_2_vld), 0);
    chk("arst_ready", 32'(fetch_ready), 1);
    chk("arst_empty", 32'(fb_empty), 1);
    q.delete();
    @(negedge clk);
    rst = 1'b1;

    // Empty-buffer latency.
    step(1, 16'hB00F, 0, 16'h0000, 0, 0);
    chk("byp_count", 32'(fb_count), BYP ? 0 : 1);
    step(0, 16'h0000, 0, 16'h0000, 0, 0);
    step(0, 16'h0000, 0, 16'h0000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
